serial_subtractor: RTL



---
 rtl/alu_pkg.sv | 24 ++
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/full_subtractor.sv | 11 +
 rtl/serial_subtractor.sv | 116 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU datapath: subtract-unit FSM states, the NZCV
// flag bundle and the default data width.
package alu_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  typedef struct packed {
    logic n;  // result MSB
    logic z;  // result is zero
    logic c;  // carry = not borrow
    logic v;  // signed overflow
  } nzcv_t;

  // Flag value held while no result has been produced yet. C is the inverse
  // of borrow, so it idles high to keep borrow_out low.
  localparam nzcv_t FLAGS_RESET = '{n: 1'b0, z: 1'b0, c: 1'b1, v: 1'b0};

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and result bus between the issuing control logic
// (master) and the bit-serial subtract unit (slave).
interface serial_subtractor_if #(
  parameter int WIDTH = alu_pkg::DATA_W
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             zero;
  logic             negative;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, zero, negative, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, zero, negative, overflow
  );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: x - y - borrow_in.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic borrow_in,
  output logic diff_bit,
  output logic borrow_out
);
  assign diff_bit   = x ^ y ^ borrow_in;
  assign borrow_out = (~x & y) | (~(x ^ y) & borrow_in);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtract unit: diff = a - b, one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow. Result and
// NZCV-style flags are registered and only change on the final bit's edge.
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sub_state_t       state, state_next;
  logic [WIDTH-1:0] opa, opb, res;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] count;
  logic             borrow, borrow_next;
  logic             d_bit;
  logic             a_msb, b_msb;
  logic             last_bit;
  nzcv_t            flags_q, flags_next;

  full_subtractor u_fs (
    .x          (opa[0]),
    .y          (opb[0]),
    .borrow_in  (borrow),
    .diff_bit   (d_bit),
    .borrow_out (borrow_next)
  );

  assign last_bit = (count == LAST_CNT);
  assign res_next = {d_bit, res[WIDTH-1:1]};

  // Flags as they will be once the final bit lands in the result.
  always_comb begin
    flags_next.n = d_bit;
    flags_next.z = (res_next == '0);
    flags_next.c = ~borrow_next;
    flags_next.v = (a_msb ^ b_msb) & (d_bit ^ a_msb);
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand/result shifting, borrow chain, bit counter and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      opa     <= '0;
      opb     <= '0;
      res     <= '0;
      borrow  <= 1'b0;
      count   <= '0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      diff_q  <= '0;
      flags_q <= FLAGS_RESET;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            opa    <= bus.a;
            opb    <= bus.b;
            a_msb  <= bus.a[WIDTH-1];
            b_msb  <= bus.b[WIDTH-1];
            res    <= '0;
            borrow <= 1'b0;
            count  <= '0;
          end
        end
        RUN: begin
          opa    <= opa >> 1;
          opb    <= opb >> 1;
          res    <= res_next;
          borrow <= borrow_next;
          count  <= count + 1'b1;
          if (last_bit) begin
            diff_q  <= res_next;
            flags_q <= flags_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = ~flags_q.c;
  assign bus.zero       = flags_q.z;
  assign bus.negative   = flags_q.n;
  assign bus.overflow   = flags_q.v;

endmodule
